// File: rtl/watch_pkg.sv
// Shared definitions for the stopwatch run/lap controller.
//   state_e    : run FSM encoding (IDLE, RUN, LAP, STOP)
//   bcd_t      : one BCD digit
//   BLANK_IDLE : blank mask shown while cleared (lap-count digits dark)
//   bcd_tens / bcd_units : split a 0..99 integer into BCD digits
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] BLANK_IDLE = 8'hC0;

  function automatic bcd_t bcd_tens(int unsigned v);
    return bcd_t'(v / 10);
  endfunction

  function automatic bcd_t bcd_units(int unsigned v);
    return bcd_t'(v % 10);
  endfunction

endpackage

// File: rtl/watch_run_ctrl_if.sv
// Signal bundle between the button/watch-core side and the run controller.
//   ss_tgl, lap_tgl : debounced toggle levels (each change is one press)
//   blink_tick      : one-cycle blink-rate strobe
//   live            : watch core digits Q5..Q0, Q0 in [3:0]
//   run, clr        : count enable and one-cycle clear to the watch core
//   disp, blank     : digits D7..D0 and per-digit blank mask to the display
// master drives the inputs of the controller, slave is the controller.
interface watch_run_ctrl_if;
  logic        ss_tgl;
  logic        lap_tgl;
  logic        blink_tick;
  logic [23:0] live;
  logic        run;
  logic        clr;
  logic [31:0] disp;
  logic [7:0]  blank;

  modport master (
    output ss_tgl, lap_tgl, blink_tick, live,
    input  run, clr, disp, blank
  );

  modport slave (
    input  ss_tgl, lap_tgl, blink_tick, live,
    output run, clr, disp, blank
  );
endinterface

// File: rtl/watch_run_ctrl_bcd2_counter.sv
// Two-digit BCD counter used for the lap count.
//   clk, rstn : clock, asynchronous active-low reset
//   inc_i     : advance by one, wrapping from WRAP to 00
//   clr_i     : synchronous clear to 00 (wins over inc_i)
//   tens_o, units_o : registered count digits
module bcd2_counter
  import watch_pkg::*;
#(
  parameter int unsigned WRAP = 99
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc_i,
  input  logic clr_i,
  output bcd_t tens_o,
  output bcd_t units_o
);

  localparam bcd_t WRAP_TENS  = bcd_tens(WRAP);
  localparam bcd_t WRAP_UNITS = bcd_units(WRAP);

  bcd_t tens_q, tens_d;
  bcd_t units_q, units_d;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr_i) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc_i) begin
      if (tens_q == WRAP_TENS && units_q == WRAP_UNITS) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 4'd1;
        units_d = '0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_o  = tens_q;
  assign units_o = units_q;

endmodule

// File: rtl/watch_run_ctrl.sv
// Stopwatch run/lap controller.
// Turns start/stop and lap/clear toggle levels into a four-state run FSM,
// drives the watch core's count enable and clear, and selects what the
// 8-digit display shows (live time, frozen lap capture, lap count on D7..D6).
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : watch_run_ctrl_if.slave (toggles, blink strobe, live digits
//               in; run, clr, disp, blank out -- all outputs registered)
//   LAP_WRAP  : last lap-count value before wrapping to 00 (1..99)
//   BLINK_EN  : 1 = lap-count digits blink while a lap is frozen
module watch_run_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned LAP_WRAP = 99,
  parameter bit          BLINK_EN = 1'b1
) (
  input logic             clk,
  input logic             rstn,
  watch_run_ctrl_if.slave bus
);

  logic        ss_q, lap_q, armed_q;
  logic        ss_p, lap_p;
  state_e      state_q, state_d;
  logic [23:0] lap_reg_q, lap_reg_d;
  logic        blink_ph_q, blink_ph_d;
  logic        run_q, run_d;
  logic        clr_q, clr_d;
  logic [23:0] disp_lo_q, disp_lo_d;
  logic [7:0]  blank_q, blank_d;
  logic        enter_lap, cnt_clr;
  bcd_t        cnt_tens, cnt_units;

  // armed_q stays low for the first edge after reset so a toggle level that
  // moved during reset is loaded into ss_q/lap_q without counting as a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ss_q    <= 1'b0;
      lap_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      ss_q    <= bus.ss_tgl;
      lap_q   <= bus.lap_tgl;
      armed_q <= 1'b1;
    end
  end

  // Start/stop wins over a simultaneous lap press.
  assign ss_p  = armed_q & (bus.ss_tgl ^ ss_q);
  assign lap_p = armed_q & (bus.lap_tgl ^ lap_q) & ~ss_p;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_p) state_d = RUN;
      RUN:     if (ss_p) state_d = STOP; else if (lap_p) state_d = LAP;
      LAP:     if (ss_p) state_d = STOP; else if (lap_p) state_d = RUN;
      STOP:    if (ss_p) state_d = RUN;  else if (lap_p) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_lap = (state_q == RUN)  && (state_d == LAP);
  assign cnt_clr   = (state_q == STOP) && (state_d == IDLE);

  // Outputs are computed from the next state so they change on the same
  // edge as the state itself.
  always_comb begin
    lap_reg_d  = enter_lap ? bus.live : lap_reg_q;
    blink_ph_d = enter_lap ? 1'b0 : (blink_ph_q ^ bus.blink_tick);
    run_d      = (state_d == RUN) || (state_d == LAP);
    clr_d      = cnt_clr;
    disp_lo_d  = (state_d == LAP) ? lap_reg_d : bus.live;
    if (state_d == IDLE)
      blank_d = BLANK_IDLE;
    else if (state_d == LAP && BLINK_EN)
      blank_d = {{2{blink_ph_d}}, 6'b0};
    else
      blank_d = 8'h00;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lap_reg_q  <= '0;
      blink_ph_q <= 1'b0;
      run_q      <= 1'b0;
      clr_q      <= 1'b0;
      disp_lo_q  <= '0;
      blank_q    <= BLANK_IDLE;
    end else begin
      lap_reg_q  <= lap_reg_d;
      blink_ph_q <= blink_ph_d;
      run_q      <= run_d;
      clr_q      <= clr_d;
      disp_lo_q  <= disp_lo_d;
      blank_q    <= blank_d;
    end
  end

  bcd2_counter #(.WRAP(LAP_WRAP)) u_lap_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .inc_i   (enter_lap),
    .clr_i   (cnt_clr),
    .tens_o  (cnt_tens),
    .units_o (cnt_units)
  );

  // Lap-count digits come straight from the counter registers.
  assign bus.run   = run_q;
  assign bus.clr   = clr_q;
  assign bus.disp  = {cnt_tens, cnt_units, disp_lo_q};
  assign bus.blank = blank_q;

endmodule

// File: tb/tb_watch_run_ctrl.sv
module tb_watch_run_ctrl;
  localparam int unsigned WRAP = 9;

  logic clk = 1'b0;
  logic rstn;

  watch_run_ctrl_if bus();

  watch_run_ctrl #(.LAP_WRAP(WRAP), .BLINK_EN(1'b1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural view: counting / frozen / cleared flags and an integer lap count.
  bit          m_armed, m_prev_ss, m_prev_lap;
  bit          m_counting, m_frozen, m_cleared, m_ph;
  int          m_laps;
  logic [23:0] m_hold;
  logic        e_run, e_clr;
  logic [31:0] e_disp;
  logic [7:0]  e_blank;

  logic [7:0] lapseq [10] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                              8'h07, 8'h08, 8'h09, 8'h00, 8'h01};

  function automatic logic [7:0] bcd8(int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    m_armed = 0; m_prev_ss = 0; m_prev_lap = 0;
    m_counting = 0; m_frozen = 0; m_cleared = 1; m_ph = 0;
    m_laps = 0; m_hold = '0;
    e_run = 0; e_clr = 0; e_disp = '0; e_blank = 8'hC0;
  endtask

  // Predict the outputs after the coming rising edge from the current inputs.
  task automatic model_edge();
    bit ssp, lapp, entered;
    if (!rstn) begin
      model_reset();
      return;
    end
    ssp  = m_armed && (bus.ss_tgl != m_prev_ss);
    lapp = m_armed && (bus.lap_tgl != m_prev_lap) && !ssp;
    m_armed = 1; m_prev_ss = bus.ss_tgl; m_prev_lap = bus.lap_tgl;
    entered = 0;
    e_clr   = 0;
    if (ssp) begin
      m_counting = !m_counting;
      m_frozen   = 0;
      m_cleared  = 0;
    end else if (lapp) begin
      if (m_counting && !m_frozen) begin
        m_frozen = 1;
        m_hold   = bus.live;
        m_laps   = (m_laps == int'(WRAP)) ? 0 : m_laps + 1;
        entered  = 1;
      end else if (m_counting) begin
        m_frozen = 0;
      end else if (!m_cleared) begin
        m_cleared = 1;
        m_laps    = 0;
        e_clr     = 1;
      end
    end
    if (entered) m_ph = 0;
    else if (bus.blink_tick) m_ph = !m_ph;
    e_run   = m_counting;
    e_disp  = {bcd8(m_laps), m_frozen ? m_hold : bus.live};
    e_blank = (m_cleared && !m_counting) ? 8'hC0 :
              m_frozen ? {m_ph, m_ph, 6'b0} : 8'h00;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("run",   32'(bus.run),   32'(e_run));
    chk("clr",   32'(bus.clr),   32'(e_clr));
    chk("disp",  bus.disp,       e_disp);
    chk("blank", 32'(bus.blank), 32'(e_blank));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.ss_tgl = 1'b0; bus.lap_tgl = 1'b0; bus.blink_tick = 1'b0; bus.live = '0;
    model_reset();
    step(); step();
    // Toggle level moves while held in reset.
    bus.ss_tgl = 1'b1;
    step();
    chk("rst_run",   32'(bus.run),   32'd0);
    chk("rst_clr",   32'(bus.clr),   32'd0);
    chk("rst_blank", 32'(bus.blank), 32'hC0);
    chk("rst_disp",  bus.disp,       32'h0);
    rstn = 1'b1;
    step(); step(); step();
    chk("rel_run",   32'(bus.run),   32'd0);
    chk("rel_blank", 32'(bus.blank), 32'hC0);
    chk("rel_disp",  bus.disp,       32'h0);

    // Start, then stop with static live time.
    bus.live = 24'h012345; bus.ss_tgl = 1'b0;
    step();
    chk("start_run", 32'(bus.run), 32'd1);
    bus.ss_tgl = 1'b1;
    step();
    chk("stop_run",   32'(bus.run),   32'd0);
    chk("stop_disp",  bus.disp,       32'h00012345);
    chk("stop_blank", 32'(bus.blank), 32'h00);

    // Lap capture while running.
    bus.ss_tgl = 1'b0;
    step();
    bus.live = 24'h000159;
    step();
    bus.lap_tgl = 1'b1;
    step();
    chk("lap_disp", bus.disp,     32'h01000159);
    chk("lap_run",  32'(bus.run), 32'd1);
    bus.live = 24'h000200;
    step();
    chk("lap_hold", bus.disp, 32'h01000159);
    bus.blink_tick = 1'b1;
    step();
    bus.blink_tick = 1'b0;
    chk("lap_blink", 32'(bus.blank), 32'hC0);
    step();
    bus.lap_tgl = 1'b0;
    step();
    chk("release_disp", bus.disp, 32'h01000200);

    // Ten more laps: count wraps 09 -> 00 -> 01.
    for (int i = 0; i < 10; i++) begin
      bus.live = 24'h000300 + 24'(i);
      bus.lap_tgl = ~bus.lap_tgl;
      step();
      chk("lapcnt", 32'(bus.disp[31:24]), 32'(lapseq[i]));
      bus.lap_tgl = ~bus.lap_tgl;
      step();
    end

    // Simultaneous presses: start/stop wins.
    bus.live = 24'h123456;
    bus.ss_tgl = 1'b1; bus.lap_tgl = 1'b1;
    step();
    chk("both_disp", bus.disp,     32'h01123456);
    chk("both_run",  32'(bus.run), 32'd0);

    // Clear from STOP.
    bus.lap_tgl = 1'b0;
    step();
    chk("clr_pulse", 32'(bus.clr),   32'd1);
    chk("clr_cnt",   32'(bus.disp[31:24]), 32'h00);
    chk("clr_blank", 32'(bus.blank), 32'hC0);
    step();
    chk("clr_once",  32'(bus.clr),   32'd0);

    // Lap press in IDLE does nothing.
    bus.lap_tgl = 1'b1;
    step(); step();
    chk("idle_lap_run",   32'(bus.run),   32'd0);
    chk("idle_lap_blank", 32'(bus.blank), 32'hC0);

    // LAP -> STOP shows live time.
    bus.ss_tgl = 1'b0;
    step();
    bus.live = 24'h000777; bus.lap_tgl = 1'b0;
    step();
    bus.live = 24'h000888; bus.ss_tgl = 1'b1;
    step();
    chk("lapstop_disp", bus.disp,     32'h01000888);
    chk("lapstop_run",  32'(bus.run), 32'd0);

    // Blink ticks in RUN keep digits lit; tick on lap entry is overridden.
    bus.ss_tgl = 1'b0;
    step();
    bus.blink_tick = 1'b1;
    step(); step(); step();
    chk("run_blank", 32'(bus.blank), 32'h00);
    bus.lap_tgl = 1'b1;
    step();
    bus.blink_tick = 1'b0;
    chk("entry_blank", 32'(bus.blank), 32'h00);
    chk("entry_cnt",   32'(bus.disp[31:24]), 32'h02);
    step();

    // Asynchronous reset mid-operation.
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("arst_run",   32'(bus.run),   32'd0);
    chk("arst_blank", 32'(bus.blank), 32'hC0);
    chk("arst_disp",  bus.disp,       32'h0);
    compare_model();
    bus.ss_tgl = ~bus.ss_tgl;
    step(); step();
    rstn = 1'b1;
    step(); step();
    chk("arst_rel_run", 32'(bus.run), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
